pixel_frame_ctrl: RTL and testbench
===================================

# pixel_frame_ctrl

Frame sequencer and readout scheduler for the 4-pixel sensor array. On a start request it drives the ERASE, EXPOSE and CONVERT phases with programmable durations. During CONVERT it runs the 8-bit ramp/code counter. It then reads the four pixels onto the shared 8-bit data path one at a time, delivering each sample to downstream logic over a valid/ready handshake. It sits between the host/control logic and PIXEL_ARRAY, and is the single owner of the array's phase strobes and READ lines.

## Interface
- ERASE_CYCLES, default 5: ERASE phase length in cycles (≥1).
- EXP_W, default 8: width of the exposure-time input.
- CNT_W, default 8: ramp counter width; CONVERT lasts 2**CNT_W cycles.
- CLK  in  1  clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  level; sampled only in IDLE.
- CONTINUOUS  in  1  when 1 at frame end, the next frame starts without START.
- ABORT  in  1  synchronous abort, any state.
- EXP_TIME  in  EXP_W  exposure cycles; latched on frame start; 0 is treated as 1.
- DATA_IN  in  8  pixel sample from the array bus, valid while READ[i] is high.
- OUT_READY  in  1  downstream accepts the sample.
- ERASE, EXPOSE, CONVERT  out  1 each  phase strobes to the array.
- COUNT  out  CNT_W  ramp code; 0 outside CONVERT.
- READ  out  4  one-hot pixel select; 0 outside readout.
- OUT_DATA  out  8  captured sample.
- OUT_PIX  out  2  index of OUT_DATA's pixel.
- OUT_VALID  out  1  sample available.
- FRAME_DONE  out  1  single-cycle pulse after the last transfer.
- BUSY  out  1  high in every state except IDLE.
- FRAME_CNT  out  16  completed-frame count; wraps at 65535→0.

## Operation
- States: IDLE, ERASE, EXPOSE, CONVERT, RD_DRIVE, RD_WAIT, DONE.
- IDLE: all strobes are 0. START=1 → ERASE, and EXP_TIME is latched.
- ERASE: ERASE=1 for exactly ERASE_CYCLES cycles → EXPOSE.
- EXPOSE: EXPOSE=1 for max(EXP_TIME_latched, 1) cycles → CONVERT.
- CONVERT: CONVERT=1 for 2**CNT_W cycles. COUNT=0 in the first cycle, increments by 1 each cycle, and reaches 255 in the last cycle. Then go to RD_DRIVE with pixel index 3.
- RD_DRIVE(i): READ = one-hot bit i for one cycle. At the end of that cycle, DATA_IN → OUT_DATA and i → OUT_PIX. Go to RD_WAIT.
- RD_WAIT: READ=0 and OUT_VALID=1. OUT_DATA and OUT_PIX hold until OUT_READY=1.
  - On transfer with i>0: go to RD_DRIVE(i-1).
  - On transfer with i=0: go to DONE.
- Readout order is pixel 3, 2, 1, 0.
- DONE: FRAME_DONE=1 for one cycle and FRAME_CNT increments. Next state is ERASE if CONTINUOUS=1 (re-latching EXP_TIME), else IDLE.
- ERASE, EXPOSE, CONVERT and any READ bit are mutually exclusive, and are all 0 in IDLE and DONE.
- ABORT=1 → IDLE on the next edge from any state, with these effects:
  - all strobes, COUNT and OUT_VALID go to 0;
  - no FRAME_DONE is issued and FRAME_CNT is unchanged;
  - OUT_DATA and OUT_PIX keep their last values.
- ABORT takes priority over START.
- START in any state other than IDLE is ignored. EXP_TIME changes mid-frame have no effect.

## Timing
- RESET asserted: immediately go to IDLE. All outputs are 0, including OUT_DATA, OUT_PIX and FRAME_CNT.
- RESET mid-frame: the frame is lost, with no FRAME_DONE.
- Deassertion is sampled on the next rising edge.
- START sampled high at edge t: ERASE is high for cycles t+1 … t+ERASE_CYCLES, and BUSY rises at t+1.
- With E=ERASE_CYCLES and X=max(EXP_TIME,1), the frame is 2 + E + X + 2**CNT_W + 4·(1 + W) cycles long, where W ≥ 1 is the per-sample wait including the accept cycle.
- With OUT_READY tied high, each pixel takes 2 cycles.
- The OUT_VALID / OUT_READY handshake completes on the edge where both are high. OUT_VALID never drops without a transfer, except on ABORT or RESET.
- FRAME_CNT updates on the same edge that leaves DONE.

## Test plan
- Reset, then START=1 with EXP_TIME=3, ERASE_CYCLES=5, OUT_READY=1 → ERASE 5 cycles, EXPOSE 3 cycles, CONVERT 256 cycles (COUNT 0→255), READ=1000, 0100, 0010, 0001, OUT_PIX=3,2,1,0, one FRAME_DONE, FRAME_CNT=1.
- DATA_IN driven with 0xA3, 0x5C, 0x01, 0xFF during the respective READ cycles → OUT_DATA sequence is exactly those values. Holding OUT_READY=0 for 10 cycles on pixel 2 keeps OUT_VALID=1, OUT_DATA=0x5C and READ=0 stable.
- EXP_TIME=0 → EXPOSE is high for exactly 1 cycle. Changing EXP_TIME to 9 during ERASE → EXPOSE is still 1 cycle.
- ABORT asserted at COUNT=100 → next cycle in IDLE, CONVERT=0, COUNT=0, no FRAME_DONE, FRAME_CNT unchanged. START afterwards runs a full normal frame.
- CONTINUOUS=1 for 3 frames → ERASE rises on the cycle after each DONE, and FRAME_CNT=3. A preloaded 65535 wraps to 0.
- RESET asserted asynchronously mid-readout (OUT_VALID=1) → all outputs read 0 before the next clock edge.

Source files
------------

// File: rtl/pixel_frame_ctrl.sv
// ============================================================================
// pixel_frame_ctrl: erase/expose/convert sequencer and 4-pixel readout
// scheduler with a valid/ready sample output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pixel_frame_ctrl #(
  parameter int ERASE_CYCLES = 5,
  parameter int EXP_W        = 8,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_continuous,
  input  logic             i_abort,
  input  logic [EXP_W-1:0] i_exp_time,
  input  logic [7:0]       i_data_in,
  input  logic             i_out_ready,
  output logic             o_erase,
  output logic             o_expose,
  output logic             o_convert,
  output logic [CNT_W-1:0] o_count,
  output logic [3:0]       o_read,
  output logic [7:0]       o_out_data,
  output logic [1:0]       o_out_pix,
  output logic             o_out_valid,
  output logic             o_frame_done,
  output logic             o_busy,
  output logic [15:0]      o_frame_cnt
);

  localparam int c_ERASE_W = $clog2(ERASE_CYCLES + 1);
  localparam int c_TMR_W   = (EXP_W > c_ERASE_W) ? EXP_W : c_ERASE_W;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ERASE    = 3'd1,
    S_EXPOSE   = 3'd2,
    S_CONVERT  = 3'd3,
    S_RD_DRIVE = 3'd4,
    S_RD_WAIT  = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t             r_state;
  logic [c_TMR_W-1:0] r_timer;
  logic [EXP_W-1:0]   r_exp_len;
  logic [1:0]         r_idx;
  logic [EXP_W-1:0]   w_exp_len;

  // A zero exposure request still exposes for one cycle.
  assign w_exp_len = (i_exp_time == '0) ? EXP_W'(1) : i_exp_time;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_exp_len    <= '0;
      r_idx        <= '0;
      o_erase      <= 1'b0;
      o_expose     <= 1'b0;
      o_convert    <= 1'b0;
      o_count      <= '0;
      o_read       <= '0;
      o_out_data   <= '0;
      o_out_pix    <= '0;
      o_out_valid  <= 1'b0;
      o_frame_done <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_cnt  <= '0;
    end else if (i_abort) begin
      r_state      <= S_IDLE;
      o_erase      <= 1'b0;
      o_expose     <= 1'b0;
      o_convert    <= 1'b0;
      o_count      <= '0;
      o_read       <= '0;
      o_out_valid  <= 1'b0;
      o_frame_done <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state   <= S_ERASE;
            r_timer   <= c_TMR_W'(ERASE_CYCLES - 1);
            r_exp_len <= w_exp_len;
            o_erase   <= 1'b1;
            o_busy    <= 1'b1;
          end
        end
        S_ERASE: begin
          if (r_timer == '0) begin
            r_state  <= S_EXPOSE;
            r_timer  <= c_TMR_W'(r_exp_len - EXP_W'(1));
            o_erase  <= 1'b0;
            o_expose <= 1'b1;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_EXPOSE: begin
          if (r_timer == '0) begin
            r_state   <= S_CONVERT;
            o_expose  <= 1'b0;
            o_convert <= 1'b1;
            o_count   <= '0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_CONVERT: begin
          if (o_count == '1) begin
            r_state   <= S_RD_DRIVE;
            o_convert <= 1'b0;
            o_count   <= '0;
            r_idx     <= 2'd3;
            o_read    <= 4'b1000;
          end else begin
            o_count <= o_count + 1'b1;
          end
        end
        S_RD_DRIVE: begin
          r_state     <= S_RD_WAIT;
          o_out_data  <= i_data_in;
          o_out_pix   <= r_idx;
          o_read      <= '0;
          o_out_valid <= 1'b1;
        end
        S_RD_WAIT: begin
          if (i_out_ready) begin
            o_out_valid <= 1'b0;
            if (r_idx == 2'd0) begin
              r_state      <= S_DONE;
              o_frame_done <= 1'b1;
            end else begin
              r_state <= S_RD_DRIVE;
              r_idx   <= r_idx - 2'd1;
              o_read  <= 4'b0001 << (r_idx - 2'd1);
            end
          end
        end
        S_DONE: begin
          o_frame_done <= 1'b0;
          o_frame_cnt  <= o_frame_cnt + 16'd1;
          if (i_continuous) begin
            r_state   <= S_ERASE;
            r_timer   <= c_TMR_W'(ERASE_CYCLES - 1);
            r_exp_len <= w_exp_len;
            o_erase   <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pixel_frame_ctrl.sv
// ============================================================================
// tb_pixel_frame_ctrl: directed frames with a queue-based scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pixel_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_continuous = 1'b0;
  logic        i_abort = 1'b0;
  logic [7:0]  i_exp_time = 8'd0;
  logic [7:0]  i_data_in;
  logic        i_out_ready = 1'b1;
  logic        o_erase, o_expose, o_convert;
  logic [7:0]  o_count;
  logic [3:0]  o_read;
  logic [7:0]  o_out_data;
  logic [1:0]  o_out_pix;
  logic        o_out_valid, o_frame_done, o_busy;
  logic [15:0] o_frame_cnt;

  pixel_frame_ctrl #(.ERASE_CYCLES(5), .EXP_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_continuous(i_continuous),
    .i_abort(i_abort), .i_exp_time(i_exp_time), .i_data_in(i_data_in),
    .i_out_ready(i_out_ready), .o_erase(o_erase), .o_expose(o_expose),
    .o_convert(o_convert), .o_count(o_count), .o_read(o_read),
    .o_out_data(o_out_data), .o_out_pix(o_out_pix), .o_out_valid(o_out_valid),
    .o_frame_done(o_frame_done), .o_busy(o_busy), .o_frame_cnt(o_frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         q_ph_id[$];
  int         q_ph_len[$];
  logic [9:0] q_data[$];
  int         q_done_cnt[$];
  int         q_done_er[$];
  logic [7:0] pix_val[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Array model: present the selected pixel's value while its READ line is high.
  always @(negedge clk) begin
    i_data_in = 8'hEE;
    for (int i = 0; i < 4; i++)
      if (o_read[i]) i_data_in = pix_val[i];
  end

  int         run[3];
  int         done_seen = 0;
  int         done_pend = 0;
  int         pend_cnt, pend_er;
  logic [2:0] ph;
  logic [9:0] exp_d;

  always @(negedge clk) begin
    if (rst) begin
      run[0] = 0; run[1] = 0; run[2] = 0;
      done_pend = 0;
    end else begin
      ph = {o_convert, o_expose, o_erase};
      chk("strobe_excl",
          (($countones({o_erase, o_expose, o_convert, o_read}) <= 1) &&
           (o_convert || o_count == 8'd0)) ? 1 : 0, 1);
      if (o_convert) chk("count", int'(o_count), run[2]);
      for (int p = 0; p < 3; p++) begin
        if (ph[p]) run[p]++;
        else if (run[p] > 0) begin
          chk("phase_expected", (q_ph_id.size() > 0) ? 1 : 0, 1);
          if (q_ph_id.size() > 0) begin
            chk("phase_id", p, q_ph_id.pop_front());
            chk("phase_len", run[p], q_ph_len.pop_front());
          end
          run[p] = 0;
        end
      end
      if (o_out_valid && i_out_ready) begin
        chk("sample_expected", (q_data.size() > 0) ? 1 : 0, 1);
        if (q_data.size() > 0) begin
          exp_d = q_data.pop_front();
          chk("out_pix", int'(o_out_pix), int'(exp_d[9:8]));
          chk("out_data", int'(o_out_data), int'(exp_d[7:0]));
        end
      end
      if (done_pend != 0) begin
        chk("frame_cnt", int'(o_frame_cnt), pend_cnt);
        chk("erase_after_done", int'(o_erase), pend_er);
        done_pend = 0;
      end
      if (o_frame_done) begin
        done_seen++;
        chk("done_expected", (q_done_cnt.size() > 0) ? 1 : 0, 1);
        if (q_done_cnt.size() > 0) begin
          pend_cnt  = q_done_cnt.pop_front();
          pend_er   = q_done_er.pop_front();
          done_pend = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_phase(input int id, input int len);
    q_ph_id.push_back(id);
    q_ph_len.push_back(len);
  endtask

  task automatic push_frame(input int x, input logic [7:0] v3, input logic [7:0] v2,
                            input logic [7:0] v1, input logic [7:0] v0,
                            input int cnt, input int er_next);
    push_phase(0, 5);
    push_phase(1, x);
    push_phase(2, 256);
    pix_val[3] = v3; pix_val[2] = v2; pix_val[1] = v1; pix_val[0] = v0;
    q_data.push_back({2'd3, v3});
    q_data.push_back({2'd2, v2});
    q_data.push_back({2'd1, v1});
    q_data.push_back({2'd0, v0});
    q_done_cnt.push_back(cnt);
    q_done_er.push_back(er_next);
  endtask

  task automatic start_frame();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("busy_rise", int'(o_busy), 1);
    chk("erase_rise", int'(o_erase), 1);
  endtask

  task automatic wait_done();
    int target;
    int n;
    target = done_seen + 1;
    n = 0;
    while (done_seen < target && n < 3000) begin
      tick();
      n++;
    end
    chk("done_timeout", (done_seen >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_read(input logic [3:0] pat);
    int n;
    n = 0;
    while (o_read != pat && n < 1000) begin
      tick();
      n++;
    end
    chk("read_timeout", int'(o_read), int'(pat));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, int'({o_erase, o_expose, o_convert, o_read, o_out_valid,
                              o_frame_done, o_busy}), 0);
    chk({name, "_count"}, int'(o_count), 0);
    chk({name, "_data"}, int'({o_out_pix, o_out_data}), 0);
    chk({name, "_fcnt"}, int'(o_frame_cnt), 0);
  endtask

  initial begin
    int n;
    pix_val[0] = 8'h00; pix_val[1] = 8'h00; pix_val[2] = 8'h00; pix_val[3] = 8'h00;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Frame 1: exposure 3, pixel 2 stalled for 10 cycles.
    i_exp_time = 8'd3;
    push_frame(3, 8'hA3, 8'h5C, 8'h01, 8'hFF, 1, 0);
    start_frame();
    wait_read(4'b0100);
    i_out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("stall_valid", int'(o_out_valid), 1);
      chk("stall_data", int'(o_out_data), 8'h5C);
      chk("stall_pix", int'(o_out_pix), 2);
      chk("stall_read", int'(o_read), 0);
    end
    i_out_ready = 1'b1;
    wait_done();
    tick(); tick();

    // Frame 2: zero exposure, mid-frame exposure change must not matter.
    i_exp_time = 8'd0;
    push_frame(1, 8'h12, 8'h34, 8'h56, 8'h78, 2, 0);
    start_frame();
    i_exp_time = 8'd9;
    wait_done();
    tick(); tick();

    // Frame 3: abort during conversion at code 100.
    i_exp_time = 8'd4;
    push_phase(0, 5);
    push_phase(1, 4);
    push_phase(2, 101);
    start_frame();
    n = 0;
    while (o_count != 8'd100 && n < 1000) begin
      tick();
      n++;
    end
    chk("abort_wait", int'(o_count), 100);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("abort_convert", int'(o_convert), 0);
    chk("abort_count", int'(o_count), 0);
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_valid", int'(o_out_valid), 0);
    chk("abort_fcnt", int'(o_frame_cnt), 2);
    chk("abort_keep_data", int'({o_out_pix, o_out_data}), int'({2'd0, 8'h78}));
    tick(); tick();
    i_start = 1'b1;
    i_abort = 1'b1;
    tick();
    i_start = 1'b0;
    i_abort = 1'b0;
    chk("abort_prio_busy", int'(o_busy), 0);
    chk("abort_prio_erase", int'(o_erase), 0);
    tick();

    // Frame 4: normal frame after abort.
    i_exp_time = 8'd2;
    push_frame(2, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 3, 0);
    start_frame();
    wait_done();
    tick(); tick();

    // Frames 5-7: continuous mode, released during the last frame.
    i_exp_time = 8'd1;
    push_frame(1, 8'h11, 8'h22, 8'h33, 8'h44, 4, 1);
    push_frame(1, 8'h11, 8'h22, 8'h33, 8'h44, 5, 1);
    push_frame(1, 8'h11, 8'h22, 8'h33, 8'h44, 6, 0);
    i_continuous = 1'b1;
    start_frame();
    wait_done();
    wait_done();
    i_continuous = 1'b0;
    wait_done();
    tick(); tick();

    // Frame 8: asynchronous reset while a sample is pending.
    push_frame(1, 8'h55, 8'h66, 8'h77, 8'h88, 7, 0);
    start_frame();
    wait_read(4'b0010);
    i_out_ready = 1'b0;
    tick();
    chk("pre_reset_valid", int'(o_out_valid), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    q_data.delete();
    q_done_cnt.delete();
    q_done_er.delete();
    i_out_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();

    chk("left_phases", q_ph_id.size(), 0);
    chk("left_samples", q_data.size(), 0);
    chk("left_dones", q_done_cnt.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
